// File: rtl/mem_one_access.sv
// mem_one_access: second memory stage. Runs one data-memory transaction per
// accepted operation over a req/ack handshake, stalls upstream while it is
// outstanding, and emits one registered result (or fault) pulse to writeback.
module mem_one_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_m1_oper,
    input  logic        m0_m1_readmem,
    input  logic        m0_m1_writemem,
    input  logic [31:0] m0_m1_data_addr,
    input  logic [31:0] m0_m1_regb,
    input  logic [4:0]  m0_m1_regdest,
    input  logic        m0_m1_writereg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        m1_stall,
    output logic        m1_wb_oper,
    output logic [31:0] m1_wb_data,
    output logic [4:0]  m1_wb_regdest,
    output logic        m1_wb_writereg,
    output logic        m1_wb_fault
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    // Last wait count before abort: the abort fires on the edge where the
    // count of ack-less ACCESS edges reaches TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        wb_oper_q, wb_oper_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_wr_q, wb_wr_d;
    logic        wb_fault_q, wb_fault_d;

    logic        bad_access;

    // Illegal request: both access bits, or a misaligned address with any access bit.
    always_comb begin
        bad_access = (m0_m1_readmem && m0_m1_writemem) ||
                     ((m0_m1_readmem || m0_m1_writemem) && (m0_m1_data_addr[1:0] != 2'b00));
    end

    // Next-state and result logic; result fields hold unless a pulse is produced.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wb_oper_d  = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_wr_d    = wb_wr_q;
        wb_fault_d = wb_fault_q;
        case (state_q)
            IDLE: begin
                if (m0_m1_oper) begin
                    if (!m0_m1_readmem && !m0_m1_writemem) begin
                        wb_oper_d  = 1'b1;
                        wb_data_d  = m0_m1_data_addr;
                        wb_rd_d    = m0_m1_regdest;
                        wb_wr_d    = m0_m1_writereg;
                        wb_fault_d = 1'b0;
                    end else if (bad_access) begin
                        wb_oper_d  = 1'b1;
                        wb_data_d  = m0_m1_data_addr;
                        wb_rd_d    = m0_m1_regdest;
                        wb_wr_d    = 1'b0;
                        wb_fault_d = 1'b1;
                    end else begin
                        addr_d  = {m0_m1_data_addr[31:2], 2'b00};
                        wdata_d = m0_m1_regb;
                        we_d    = m0_m1_writemem;
                        rd_d    = m0_m1_regdest;
                        wr_d    = m0_m1_writereg;
                        req_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    wb_oper_d  = 1'b1;
                    wb_fault_d = 1'b0;
                    wb_rd_d    = rd_q;
                    wb_data_d  = we_q ? 32'd0 : dmem_rdata;
                    wb_wr_d    = we_q ? 1'b0 : wr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TO_LAST) begin
                        req_d      = 1'b0;
                        state_d    = IDLE;
                        wb_oper_d  = 1'b1;
                        wb_fault_d = 1'b1;
                        wb_data_d  = addr_q;
                        wb_rd_d    = rd_q;
                        wb_wr_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= 5'd0;
            wr_q       <= 1'b0;
            wb_oper_q  <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            wb_wr_q    <= 1'b0;
            wb_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wb_oper_q  <= wb_oper_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_wr_q    <= wb_wr_d;
            wb_fault_q <= wb_fault_d;
        end
    end

    // Stall tracks the outstanding request exactly.
    assign dmem_req       = req_q;
    assign m1_stall       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign m1_wb_oper     = wb_oper_q;
    assign m1_wb_data     = wb_data_q;
    assign m1_wb_regdest  = wb_rd_q;
    assign m1_wb_writereg = wb_wr_q;
    assign m1_wb_fault    = wb_fault_q;

endmodule

// File: tb/tb_mem_one_access.sv
// Directed bench for mem_one_access, built with TIMEOUT = 4.
module tb_mem_one_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_m1_oper, m0_m1_readmem, m0_m1_writemem, m0_m1_writereg;
    logic [31:0] m0_m1_data_addr, m0_m1_regb, dmem_rdata;
    logic [4:0]  m0_m1_regdest;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, m1_stall, m1_wb_oper, m1_wb_writereg, m1_wb_fault;
    logic [31:0] dmem_addr, dmem_wdata, m1_wb_data;
    logic [4:0]  m1_wb_regdest;

    int tests = 0;
    int fails = 0;

    mem_one_access #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .m0_m1_oper(m0_m1_oper), .m0_m1_readmem(m0_m1_readmem),
        .m0_m1_writemem(m0_m1_writemem), .m0_m1_data_addr(m0_m1_data_addr),
        .m0_m1_regb(m0_m1_regb), .m0_m1_regdest(m0_m1_regdest),
        .m0_m1_writereg(m0_m1_writereg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .m1_stall(m1_stall), .m1_wb_oper(m1_wb_oper), .m1_wb_data(m1_wb_data),
        .m1_wb_regdest(m1_wb_regdest), .m1_wb_writereg(m1_wb_writereg),
        .m1_wb_fault(m1_wb_fault)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic op, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dst, input logic wreg);
        m0_m1_oper = op; m0_m1_readmem = rd; m0_m1_writemem = wr;
        m0_m1_data_addr = a; m0_m1_regb = b; m0_m1_regdest = dst; m0_m1_writereg = wreg;
    endtask

    task automatic test_reset();
        reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            set_op(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 1'b1);
            dmem_ack = 1'($urandom);
            tick();
            tests++; if ({dmem_req, m1_stall, m1_wb_oper, m1_wb_fault, m1_wb_writereg} !== 5'b0 || m1_wb_data !== 32'h0 || dmem_addr !== 32'h0)
                begin fails++; $display("FAIL reset_outputs req=%0b stall=%0b oper=%0b data=%h exp all 0", dmem_req, m1_stall, m1_wb_oper, m1_wb_data); end
        end
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_ack = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        tests++; if ({dmem_req, m1_stall, m1_wb_oper, m1_wb_fault} !== 4'b0 || m1_wb_data !== 32'h0 || m1_wb_regdest !== 5'd0)
            begin fails++; $display("FAIL reset_release req=%0b oper=%0b data=%h exp 0", dmem_req, m1_wb_oper, m1_wb_data); end
    endtask

    task automatic test_load();
        int req_cycles;
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 1'b1);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        req_cycles = 0;
        tests++; if (dmem_req !== 1'b1 || m1_stall !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h10)
            begin fails++; $display("FAIL load_issue req=%0b stall=%0b we=%0b addr=%h exp 1 1 0 00000010", dmem_req, m1_stall, dmem_we, dmem_addr); end
        for (int i = 0; i < 6 && dmem_req === 1'b1; i++) begin
            req_cycles++;
            tests++; if (m1_wb_oper !== 1'b0) begin fails++; $display("FAIL load_early_oper got %0b exp 0", m1_wb_oper); end
            if (req_cycles == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
            tick();
            dmem_ack = 1'b0;
        end
        tests++; if (req_cycles !== 3) begin fails++; $display("FAIL load_req_cycles got %0d exp 3", req_cycles); end
        tests++; if (m1_wb_oper !== 1'b1 || m1_wb_data !== 32'hDEAD_BEEF || m1_wb_writereg !== 1'b1 || m1_wb_regdest !== 5'd5 || m1_wb_fault !== 1'b0 || m1_stall !== 1'b0)
            begin fails++; $display("FAIL load_result oper=%0b data=%h wr=%0b rd=%0d fault=%0b exp 1 deadbeef 1 5 0", m1_wb_oper, m1_wb_data, m1_wb_writereg, m1_wb_regdest, m1_wb_fault); end
        tick();
        tests++; if (m1_wb_oper !== 1'b0 || m1_wb_data !== 32'hDEAD_BEEF)
            begin fails++; $display("FAIL load_pulse_end oper=%0b data=%h exp 0 deadbeef", m1_wb_oper, m1_wb_data); end
    endtask

    task automatic test_store();
        set_op(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5'd7, 1'b1);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h1234_5678 || dmem_addr !== 32'h20)
            begin fails++; $display("FAIL store_issue req=%0b we=%0b wdata=%h addr=%h exp 1 1 12345678 00000020", dmem_req, dmem_we, dmem_wdata, dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack = 1'b0;
        tests++; if (dmem_req !== 1'b0 || m1_wb_oper !== 1'b1 || m1_wb_writereg !== 1'b0 || m1_wb_data !== 32'h0 || m1_wb_fault !== 1'b0)
            begin fails++; $display("FAIL store_result req=%0b oper=%0b wr=%0b data=%h fault=%0b exp 0 1 0 0 0", dmem_req, m1_wb_oper, m1_wb_writereg, m1_wb_data, m1_wb_fault); end
        tick();
    endtask

    task automatic test_faults();
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 5'd3, 1'b1);
        tick();
        tests++; if (dmem_req !== 1'b0 || m1_wb_oper !== 1'b1 || m1_wb_fault !== 1'b1 || m1_wb_data !== 32'h13 || m1_wb_writereg !== 1'b0 || m1_wb_regdest !== 5'd3)
            begin fails++; $display("FAIL misalign_fault req=%0b oper=%0b fault=%0b data=%h wr=%0b rd=%0d exp 0 1 1 00000013 0 3", dmem_req, m1_wb_oper, m1_wb_fault, m1_wb_data, m1_wb_writereg, m1_wb_regdest); end
        set_op(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 5'd6, 1'b1);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tests++; if (dmem_req !== 1'b0 || m1_wb_oper !== 1'b1 || m1_wb_fault !== 1'b1 || m1_wb_data !== 32'h40 || m1_wb_regdest !== 5'd6)
            begin fails++; $display("FAIL rw_both_fault req=%0b oper=%0b fault=%0b data=%h rd=%0d exp 0 1 1 00000040 6", dmem_req, m1_wb_oper, m1_wb_fault, m1_wb_data, m1_wb_regdest); end
        tick();
        tests++; if (dmem_req !== 1'b0 || m1_wb_oper !== 1'b0)
            begin fails++; $display("FAIL fault_no_req req=%0b oper=%0b exp 0 0", dmem_req, m1_wb_oper); end
    endtask

    task automatic test_back_to_back();
        set_op(1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0, 5'd9, 1'b1);
        tick();
        tests++; if (m1_wb_oper !== 1'b1 || m1_wb_data !== 32'hCAFE_0001 || m1_wb_regdest !== 5'd9 || m1_wb_writereg !== 1'b1 || m1_wb_fault !== 1'b0 || dmem_req !== 1'b0)
            begin fails++; $display("FAIL pass1 oper=%0b data=%h rd=%0d wr=%0b fault=%0b exp 1 cafe0001 9 1 0", m1_wb_oper, m1_wb_data, m1_wb_regdest, m1_wb_writereg, m1_wb_fault); end
        set_op(1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0, 5'd10, 1'b0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tests++; if (m1_wb_oper !== 1'b1 || m1_wb_data !== 32'h0ABC || m1_wb_regdest !== 5'd10 || m1_wb_writereg !== 1'b0)
            begin fails++; $display("FAIL pass2 oper=%0b data=%h rd=%0d wr=%0b exp 1 00000abc 10 0", m1_wb_oper, m1_wb_data, m1_wb_regdest, m1_wb_writereg); end
        tick();
        tests++; if (m1_wb_oper !== 1'b0 || m1_wb_data !== 32'h0ABC || m1_wb_regdest !== 5'd10)
            begin fails++; $display("FAIL idle_hold oper=%0b data=%h rd=%0d exp 0 00000abc 10", m1_wb_oper, m1_wb_data, m1_wb_regdest); end
    endtask

    task automatic test_timeout();
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 5'd4, 1'b1);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests++; if (dmem_req !== 1'b1 || m1_stall !== 1'b1 || m1_wb_oper !== 1'b0)
                begin fails++; $display("FAIL timeout_wait%0d req=%0b stall=%0b oper=%0b exp 1 1 0", i, dmem_req, m1_stall, m1_wb_oper); end
            tick();
        end
        tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL timeout_wait3 req=%0b exp 1", dmem_req); end
        tick();
        tests++; if (dmem_req !== 1'b0 || m1_stall !== 1'b0 || m1_wb_oper !== 1'b1 || m1_wb_fault !== 1'b1 || m1_wb_data !== 32'h30 || m1_wb_regdest !== 5'd4 || m1_wb_writereg !== 1'b0)
            begin fails++; $display("FAIL timeout_abort req=%0b oper=%0b fault=%0b data=%h rd=%0d wr=%0b exp 0 1 1 00000030 4 0", dmem_req, m1_wb_oper, m1_wb_fault, m1_wb_data, m1_wb_regdest, m1_wb_writereg); end
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        tests++; if (m1_wb_oper !== 1'b0 || dmem_req !== 1'b0 || m1_wb_data !== 32'h30)
            begin fails++; $display("FAIL late_ack oper=%0b req=%0b data=%h exp 0 0 00000030", m1_wb_oper, dmem_req, m1_wb_data); end
        tick();
        dmem_ack = 1'b0;
        tests++; if (m1_wb_oper !== 1'b0) begin fails++; $display("FAIL late_ack2 oper=%0b exp 0", m1_wb_oper); end
    endtask

    task automatic test_reset_mid_access();
        int seen_oper;
        set_op(1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 5'd2, 1'b1);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_pre req=%0b exp 1", dmem_req); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (dmem_req !== 1'b0 || m1_stall !== 1'b0)
            begin fails++; $display("FAIL rst_async_drop req=%0b stall=%0b exp 0 0", dmem_req, m1_stall); end
        seen_oper = 0;
        tick();
        if (m1_wb_oper === 1'b1) seen_oper++;
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (m1_wb_oper === 1'b1) seen_oper++;
        end
        dmem_ack = 1'b0;
        tests++; if (seen_oper !== 0 || dmem_req !== 1'b0)
            begin fails++; $display("FAIL rst_no_result pulses=%0d req=%0b exp 0 0", seen_oper, dmem_req); end
        set_op(1'b1, 1'b0, 1'b0, 32'h0000_7777, 32'h0, 5'd11, 1'b1);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tests++; if (m1_wb_oper !== 1'b1 || m1_wb_data !== 32'h7777 || m1_wb_regdest !== 5'd11 || m1_wb_fault !== 1'b0)
            begin fails++; $display("FAIL rst_then_pass oper=%0b data=%h rd=%0d fault=%0b exp 1 00007777 11 0", m1_wb_oper, m1_wb_data, m1_wb_regdest, m1_wb_fault); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_faults();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
